// File: rtl/item_ram_arbiter.sv
// Request/grant arbiter for the single-port 16x32 item RAM shared by loader, draw and rope.
// Loader has strict priority, draw/rope alternate; a lock pins the bus to one owner for RMW.
module item_ram_arbiter #(
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 64
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        enable_i,
   input  logic        req0_i,
   input  logic        we0_i,
   input  logic [3:0]  addr0_i,
   input  logic [31:0] wdata0_i,
   input  logic        lock0_i,
   input  logic        req1_i,
   input  logic        we1_i,
   input  logic [3:0]  addr1_i,
   input  logic [31:0] wdata1_i,
   input  logic        lock1_i,
   input  logic        req2_i,
   input  logic        we2_i,
   input  logic [3:0]  addr2_i,
   input  logic [31:0] wdata2_i,
   input  logic        lock2_i,
   output logic        gnt0_o,
   output logic        gnt1_o,
   output logic        gnt2_o,
   output logic        rvalid0_o,
   output logic        rvalid1_o,
   output logic        rvalid2_o,
   output logic [31:0] rdata_o,
   output logic        lock_err_o,
   output logic [3:0]  ram_addr_o,
   output logic [31:0] ram_wdata_o,
   output logic        ram_wren_o,
   input  logic [31:0] ram_q_i
);

   typedef enum logic {FREE, LOCKED} state_t;

   logic [2:0]        req, we, lock;
   logic [2:0][3:0]   addr;
   logic [2:0][31:0]  wdata;

   assign req   = {req2_i, req1_i, req0_i};
   assign we    = {we2_i, we1_i, we0_i};
   assign lock  = {lock2_i, lock1_i, lock0_i};
   assign addr  = {addr2_i, addr1_i, addr0_i};
   assign wdata = {wdata2_i, wdata1_i, wdata0_i};

   state_t            state_q, state_d;
   logic [1:0]        owner_q, owner_d;
   logic [1:0]        last_q, last_d;
   logic [6:0]        idle_q, idle_d;
   logic              err_q, err_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [3:0]        addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wren_q, wren_d;
   // One-hot requester tag per stage; last stage lines up with ram_q.
   logic [RD_LAT:0][2:0] tag_pipe_q;

   logic [2:0]        sel;
   logic [1:0]        idx;

   always_comb begin
      sel = 3'b000;
      if (enable_i) begin
         if (state_q == FREE) begin
            if (req[0])                 sel = 3'b001;
            else if (req[1] && req[2])  sel = (last_q == 2'd2) ? 3'b010 : 3'b100;
            else if (req[1])            sel = 3'b010;
            else if (req[2])            sel = 3'b100;
         end else if (req[owner_q]) begin
            sel = 3'(1) << owner_q;
         end
      end
      idx = 2'd0;
      for (int n = 0; n < 3; n++)
         if (sel[n]) idx = 2'(n);
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      idle_d  = idle_q;
      err_d   = err_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      gnt_d   = sel;
      wren_d  = 1'b0;
      if (|sel) begin
         addr_d  = addr[idx];
         wdata_d = wdata[idx];
         wren_d  = we[idx];
         idle_d  = 7'd0;
         if (sel[1]) last_d = 2'd1;
         if (sel[2]) last_d = 2'd2;
         if (lock[idx]) begin
            state_d = LOCKED;
            owner_d = idx;
         end else begin
            state_d = FREE;
         end
      end else if (state_q == LOCKED && !req[owner_q]) begin
         // Owner idle: either a clean release or a stuck lock that times out.
         if (!lock[owner_q]) begin
            state_d = FREE;
            idle_d  = 7'd0;
         end else if (idle_q == 7'(LOCK_MAX - 1)) begin
            state_d = FREE;
            idle_d  = 7'd0;
            err_d   = 1'b1;
         end else begin
            idle_d  = idle_q + 7'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q    <= FREE;
         owner_q    <= 2'd0;
         last_q     <= 2'd2;
         idle_q     <= 7'd0;
         err_q      <= 1'b0;
         gnt_q      <= 3'b000;
         addr_q     <= 4'd0;
         wdata_q    <= 32'd0;
         wren_q     <= 1'b0;
         tag_pipe_q <= '0;
      end else begin
         state_q       <= state_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         idle_q        <= idle_d;
         err_q         <= err_d;
         gnt_q         <= gnt_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wren_q        <= wren_d;
         tag_pipe_q[0] <= sel & ~we;
         for (int k = 1; k <= RD_LAT; k++)
            tag_pipe_q[k] <= tag_pipe_q[k-1];
      end
   end

   assign gnt0_o      = gnt_q[0];
   assign gnt1_o      = gnt_q[1];
   assign gnt2_o      = gnt_q[2];
   assign rvalid0_o   = tag_pipe_q[RD_LAT][0];
   assign rvalid1_o   = tag_pipe_q[RD_LAT][1];
   assign rvalid2_o   = tag_pipe_q[RD_LAT][2];
   assign rdata_o     = ram_q_i;
   assign lock_err_o  = err_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign ram_wren_o  = wren_q;

endmodule

// File: tb/tb_item_ram_arbiter.sv
// Directed bench for item_ram_arbiter: one RD_LAT=1/LOCK_MAX=4 instance and one RD_LAT=2
// instance share the stimulus, each with its own behavioural RAM.
module tb_item_ram_arbiter;

   logic        clock = 1'b0;
   logic        resetn;
   logic        enable;
   logic [2:0]  req, we, lock;
   logic [3:0]  addr [3];
   logic [31:0] wdata [3];

   logic [2:0]  gnt_a, rv_a, gnt_b, rv_b;
   logic [31:0] rdata_a, rdata_b, rwdata_a, rwdata_b, ramq_a, ramq_b;
   logic [3:0]  raddr_a, raddr_b;
   logic        err_a, err_b, rwren_a, rwren_b;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   item_ram_arbiter #(.RD_LAT(1), .LOCK_MAX(4)) u_dut (
      .clock(clock), .resetn(resetn), .enable_i(enable),
      .req0_i(req[0]), .we0_i(we[0]), .addr0_i(addr[0]), .wdata0_i(wdata[0]), .lock0_i(lock[0]),
      .req1_i(req[1]), .we1_i(we[1]), .addr1_i(addr[1]), .wdata1_i(wdata[1]), .lock1_i(lock[1]),
      .req2_i(req[2]), .we2_i(we[2]), .addr2_i(addr[2]), .wdata2_i(wdata[2]), .lock2_i(lock[2]),
      .gnt0_o(gnt_a[0]), .gnt1_o(gnt_a[1]), .gnt2_o(gnt_a[2]),
      .rvalid0_o(rv_a[0]), .rvalid1_o(rv_a[1]), .rvalid2_o(rv_a[2]),
      .rdata_o(rdata_a), .lock_err_o(err_a), .ram_addr_o(raddr_a),
      .ram_wdata_o(rwdata_a), .ram_wren_o(rwren_a), .ram_q_i(ramq_a));

   item_ram_arbiter #(.RD_LAT(2), .LOCK_MAX(64)) u_dut2 (
      .clock(clock), .resetn(resetn), .enable_i(enable),
      .req0_i(req[0]), .we0_i(we[0]), .addr0_i(addr[0]), .wdata0_i(wdata[0]), .lock0_i(lock[0]),
      .req1_i(req[1]), .we1_i(we[1]), .addr1_i(addr[1]), .wdata1_i(wdata[1]), .lock1_i(lock[1]),
      .req2_i(req[2]), .we2_i(we[2]), .addr2_i(addr[2]), .wdata2_i(wdata[2]), .lock2_i(lock[2]),
      .gnt0_o(gnt_b[0]), .gnt1_o(gnt_b[1]), .gnt2_o(gnt_b[2]),
      .rvalid0_o(rv_b[0]), .rvalid1_o(rv_b[1]), .rvalid2_o(rv_b[2]),
      .rdata_o(rdata_b), .lock_err_o(err_b), .ram_addr_o(raddr_b),
      .ram_wdata_o(rwdata_b), .ram_wren_o(rwren_b), .ram_q_i(ramq_b));

   function automatic logic [31:0] init_word(int i);
      return (i == 5) ? 32'h1234_5678 : 32'hC0DE_0000 + 32'(i) * 32'h111;
   endfunction

   // Behavioural RAMs: contents restored on reset, read latency 1 and 2.
   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [31:0] q_b1;
   always @(posedge clock) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) begin
            mem_a[i] <= init_word(i);
            mem_b[i] <= init_word(i);
         end
      end else begin
         if (rwren_a) mem_a[raddr_a] <= rwdata_a;
         if (rwren_b) mem_b[raddr_b] <= rwdata_b;
         ramq_a <= mem_a[raddr_a];
         q_b1   <= mem_b[raddr_b];
         ramq_b <= q_b1;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_req();
      req = 3'b000; we = 3'b000; lock = 3'b000;
      for (int i = 0; i < 3; i++) begin
         addr[i] = 4'd0; wdata[i] = 32'd0;
      end
   endtask

   task automatic do_reset();
      clear_req();
      resetn = 1'b0;
      step(); step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      enable = 1'b1;
      do_reset();
      n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000", gnt_a); end
      n_chk++; if (rv_a !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 000", rv_a); end
      n_chk++; if (rwren_a !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", rwren_a); end
      n_chk++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_lock_err: got %b want 0", err_a); end
      n_chk++; if (raddr_a !== 4'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", raddr_a); end
      n_chk++; if (rwdata_a !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rwdata_a); end
      n_chk++; if (rv_b !== 3'b000) begin n_fail++; $display("FAIL reset_rvalid_lat2: got %b want 000", rv_b); end
   endtask

   task automatic test_single_read();
      req[2] = 1'b1; addr[2] = 4'd5;
      step();
      n_chk++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL read_gnt: got %b want 100", gnt_a); end
      n_chk++; if (raddr_a !== 4'd5) begin n_fail++; $display("FAIL read_addr: got %0d want 5", raddr_a); end
      n_chk++; if (rwren_a !== 1'b0) begin n_fail++; $display("FAIL read_wren: got %b want 0", rwren_a); end
      clear_req();
      step();
      n_chk++; if (rv_a !== 3'b100) begin n_fail++; $display("FAIL read_rvalid: got %b want 100", rv_a); end
      n_chk++; if (rdata_a !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data: got %h want 12345678", rdata_a); end
      n_chk++; if (rv_b !== 3'b000) begin n_fail++; $display("FAIL read_rvalid_lat2_early: got %b want 000", rv_b); end
      step();
      n_chk++; if (rv_b !== 3'b100) begin n_fail++; $display("FAIL read_rvalid_lat2: got %b want 100", rv_b); end
      n_chk++; if (rdata_b !== 32'h1234_5678) begin n_fail++; $display("FAIL read_data_lat2: got %h want 12345678", rdata_b); end
   endtask

   task automatic test_contention();
      logic [2:0] exp, prev;
      do_reset();
      req[1] = 1'b1; addr[1] = 4'd1;
      req[2] = 1'b1; addr[2] = 4'd2;
      prev = 3'b000;
      for (int i = 0; i < 6; i++) begin
         step();
         exp = (i % 2 == 0) ? 3'b010 : 3'b100;
         n_chk++; if (gnt_a !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnt_a, exp); end
         n_chk++; if (rv_a !== prev) begin n_fail++; $display("FAIL rr_rvalid[%0d]: got %b want %b", i, rv_a, prev); end
         prev = exp;
      end
      req[0] = 1'b1; addr[0] = 4'd0;
      step();
      n_chk++; if (gnt_a !== 3'b001) begin n_fail++; $display("FAIL loader_prio_gnt: got %b want 001", gnt_a); end
      n_chk++; if (rdata_a !== init_word(2)) begin n_fail++; $display("FAIL rr_data2: got %h want %h", rdata_a, init_word(2)); end
      clear_req();
      step();
      n_chk++; if (rv_a !== 3'b001) begin n_fail++; $display("FAIL loader_rvalid: got %b want 001", rv_a); end
      n_chk++; if (rdata_a !== init_word(0)) begin n_fail++; $display("FAIL loader_data: got %h want %h", rdata_a, init_word(0)); end
      n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL idle_gnt: got %b want 000", gnt_a); end
   endtask

   task automatic test_lock_rmw();
      do_reset();
      req[2] = 1'b1; addr[2] = 4'd3; lock[2] = 1'b1;
      step();
      n_chk++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL rmw_read_gnt: got %b want 100", gnt_a); end
      req[2] = 1'b0;
      req[1] = 1'b1; addr[1] = 4'd3;
      step();
      n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL rmw_stall: got %b want 000", gnt_a); end
      n_chk++; if (rv_a !== 3'b100) begin n_fail++; $display("FAIL rmw_rvalid: got %b want 100", rv_a); end
      n_chk++; if (rdata_a !== init_word(3)) begin n_fail++; $display("FAIL rmw_rdata: got %h want %h", rdata_a, init_word(3)); end
      req[2] = 1'b1; we[2] = 1'b1; wdata[2] = init_word(3) + 32'd1; lock[2] = 1'b0;
      step();
      n_chk++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL rmw_write_gnt: got %b want 100", gnt_a); end
      n_chk++; if (rwren_a !== 1'b1) begin n_fail++; $display("FAIL rmw_wren: got %b want 1", rwren_a); end
      n_chk++; if (rwdata_a !== init_word(3) + 32'd1) begin n_fail++; $display("FAIL rmw_wdata: got %h want %h", rwdata_a, init_word(3) + 32'd1); end
      req[2] = 1'b0; we[2] = 1'b0;
      step();
      n_chk++; if (gnt_a !== 3'b010) begin n_fail++; $display("FAIL rmw_draw_gnt: got %b want 010", gnt_a); end
      n_chk++; if (rwren_a !== 1'b0) begin n_fail++; $display("FAIL rmw_draw_wren: got %b want 0", rwren_a); end
      n_chk++; if (gnt_b !== 3'b010) begin n_fail++; $display("FAIL rmw_draw_gnt_lat2: got %b want 010", gnt_b); end
      req[1] = 1'b0;
      step();
      n_chk++; if (rv_a !== 3'b010) begin n_fail++; $display("FAIL rmw_draw_rvalid: got %b want 010", rv_a); end
      n_chk++; if (rdata_a !== init_word(3) + 32'd1) begin n_fail++; $display("FAIL rmw_draw_data: got %h want %h", rdata_a, init_word(3) + 32'd1); end
   endtask

   task automatic test_lock_timeout();
      do_reset();
      req[2] = 1'b1; addr[2] = 4'd7; lock[2] = 1'b1;
      step();
      n_chk++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL to_lock_gnt: got %b want 100", gnt_a); end
      req[2] = 1'b0;
      req[1] = 1'b1; addr[1] = 4'd8;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL to_stall[%0d]: got %b want 000", i, gnt_a); end
         n_chk++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL to_err_early[%0d]: got %b want 0", i, err_a); end
      end
      step();
      n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL to_release_gnt: got %b want 000", gnt_a); end
      n_chk++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err_a); end
      step();
      n_chk++; if (gnt_a !== 3'b010) begin n_fail++; $display("FAIL to_draw_gnt: got %b want 010", gnt_a); end
      clear_req();
      step();
      n_chk++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL to_err_sticky: got %b want 1", err_a); end
      n_chk++; if (rdata_a !== init_word(8)) begin n_fail++; $display("FAIL to_draw_data: got %h want %h", rdata_a, init_word(8)); end
   endtask

   task automatic test_reset_mid();
      req[2] = 1'b1; addr[2] = 4'd5;
      step();
      n_chk++; if (gnt_a !== 3'b100) begin n_fail++; $display("FAIL rst_mid_gnt: got %b want 100", gnt_a); end
      clear_req();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL rst_mid_gnt0: got %b want 000", gnt_a); end
      n_chk++; if (rv_a !== 3'b000) begin n_fail++; $display("FAIL rst_mid_rvalid: got %b want 000", rv_a); end
      n_chk++; if (rwren_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wren: got %b want 0", rwren_a); end
      n_chk++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got %b want 0", err_a); end
      n_chk++; if (raddr_a !== 4'd0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d want 0", raddr_a); end
      n_chk++; if (rwdata_a !== 32'd0) begin n_fail++; $display("FAIL rst_mid_wdata: got %h want 0", rwdata_a); end
      step();
      n_chk++; if (rv_a !== 3'b000) begin n_fail++; $display("FAIL rst_mid_rvalid_late: got %b want 000", rv_a); end
      n_chk++; if (rv_b !== 3'b000) begin n_fail++; $display("FAIL rst_mid_rvalid_lat2: got %b want 000", rv_b); end
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b0;
      req = 3'b111; addr[0] = 4'd4; addr[1] = 4'd1; addr[2] = 4'd2;
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++; if (gnt_a !== 3'b000) begin n_fail++; $display("FAIL en_off_gnt[%0d]: got %b want 000", i, gnt_a); end
      end
      enable = 1'b1;
      step();
      n_chk++; if (gnt_a !== 3'b001) begin n_fail++; $display("FAIL en_on_gnt: got %b want 001", gnt_a); end
      clear_req();
      step();
      n_chk++; if (rv_a !== 3'b001) begin n_fail++; $display("FAIL en_rvalid: got %b want 001", rv_a); end
      n_chk++; if (rdata_a !== init_word(4)) begin n_fail++; $display("FAIL en_rdata: got %h want %h", rdata_a, init_word(4)); end
   endtask

   task automatic test_back_to_back_lat2();
      do_reset();
      req[1] = 1'b1; addr[1] = 4'd9;
      req[2] = 1'b1; addr[2] = 4'd10;
      step();
      n_chk++; if (gnt_b !== 3'b010) begin n_fail++; $display("FAIL b2b_gnt1: got %b want 010", gnt_b); end
      req[1] = 1'b0;
      step();
      n_chk++; if (gnt_b !== 3'b100) begin n_fail++; $display("FAIL b2b_gnt2: got %b want 100", gnt_b); end
      n_chk++; if (rv_b !== 3'b000) begin n_fail++; $display("FAIL b2b_rvalid_early: got %b want 000", rv_b); end
      req[2] = 1'b0;
      step();
      n_chk++; if (rv_b !== 3'b010) begin n_fail++; $display("FAIL b2b_rvalid1: got %b want 010", rv_b); end
      n_chk++; if (rdata_b !== init_word(9)) begin n_fail++; $display("FAIL b2b_data1: got %h want %h", rdata_b, init_word(9)); end
      n_chk++; if (rv_a !== 3'b100) begin n_fail++; $display("FAIL b2b_lat1_rvalid2: got %b want 100", rv_a); end
      step();
      n_chk++; if (rv_b !== 3'b100) begin n_fail++; $display("FAIL b2b_rvalid2: got %b want 100", rv_b); end
      n_chk++; if (rdata_b !== init_word(10)) begin n_fail++; $display("FAIL b2b_data2: got %h want %h", rdata_b, init_word(10)); end
      n_chk++; if (rv_a !== 3'b000) begin n_fail++; $display("FAIL b2b_lat1_quiet: got %b want 000", rv_a); end
   endtask

   initial begin
      resetn = 1'b0;
      enable = 1'b1;
      clear_req();
      test_reset();
      test_single_read();
      test_contention();
      test_lock_rmw();
      test_lock_timeout();
      test_reset_mid();
      test_enable();
      test_back_to_back_lat2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/item_ram_arbiter.md
# item_ram_arbiter

Arbitrates the single-port 16-entry × 32-bit item RAM between three requesters: level loader, frame draw engine and rope controller. It replaces per-module address muxing with a registered request/grant handshake, in-order read-data return and a bus lock for read-modify-write sequences (grab, move, score). It sits between the requesters and the RAM macro and is agnostic to the item word format.

## Interface
- RD_LAT, 1: RAM cycles from sampled address to valid `ram_q` (1 or 2).
- LOCK_MAX, 64: cycles a lock may stay idle (owner `req` low) before forced release.
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  grants are issued only while high; in-flight reads still complete.
- reqN  in  1  request, N ∈ {0 loader, 1 draw, 2 rope}.
- weN  in  1  1 = write, 0 = read.
- addrN  in  4  item index.
- wdataN  in  32  write data.
- lockN  in  1  keep bus ownership after this grant.
- gntN  out  1  one-cycle pulse: transfer N accepted.
- rvalidN  out  1  `rdata` holds N's read result this cycle.
- rdata  out  32  shared read data; combinational copy of `ram_q`.
- lock_err  out  1  sticky; set on forced lock release, cleared only by reset.
- ram_addr  out  4  registered RAM address.
- ram_wdata  out  32  registered RAM write data.
- ram_wren  out  1  registered RAM write enable.
- ram_q  in  32  RAM read data.

## Operation
- State FREE: each cycle with `enable`=1, choose among active requests:
  - loader (0) has strict priority;
  - otherwise round-robin between draw (1) and rope (2); pointer `last` (reset = 2, so draw wins the first tie) updates only when 1 or 2 is granted.
- On grant to N, at the clock edge:
  - `gntN`←1, `ram_addr`←`addrN`, `ram_wdata`←`wdataN`, `ram_wren`←`weN`;
  - if `weN`=0, push tag N into a (1+RD_LAT)-deep tag pipe;
  - if `lockN`=1, go to LOCKED with owner=N.
- No grant in a cycle → `ram_wren`←0; `ram_addr`/`ram_wdata` hold.
- LOCKED:
  - only the owner's requests are granted, one per cycle;
  - other requests stall without error.
- Lock release:
  - a grant to the owner with `lockN`=0 → FREE after that transfer;
  - the owner deasserting `req` and `lock` together → FREE on the next edge.
- Idle lock: `idle_cnt` (7 bits) counts cycles in LOCKED with owner `req`=0 and `lock`=1; it resets on every owner grant. At `idle_cnt`=LOCK_MAX−1 → FREE, `lock_err`←1.
- `enable`=0: no grants; state, lock and `last` are held; `idle_cnt` still counts.
- Requester rules:
  - hold `req`/`we`/`addr`/`wdata`/`lock` stable until `gnt`, then change or drop them the cycle after `gnt`;
  - keeping `req` high issues back-to-back transfers, one per cycle.
- Ordering: transfers reach the RAM in grant order. A read after a write to the same address, granted later, returns the new data.
- Reset mid-operation:
  - state←FREE, tag pipe cleared (no `rvalid` for reads in flight);
  - all `gnt*`/`rvalid*`/`ram_wren`/`lock_err`←0;
  - `ram_addr`←0, `ram_wdata`←0, `idle_cnt`←0.

## Timing
- Request sampled in cycle T; `gntN` and RAM control outputs are high in T+1.
- RAM samples the address at the end of T+1. `rvalidN` and matching `rdata` appear in T+1+RD_LAT (T+2 when RD_LAT=1).
- Minimum latency from `req` rising to `gnt` is 1 cycle. Throughput is 1 transfer/cycle.
- Under continuous contention between 1 and 2, each waits at most 1 cycle. With the loader constantly requesting, 1 and 2 starve (by design; the loader runs only at level start).
- `rvalid*` are mutually exclusive and one cycle wide. `rvalidN` is registered from the tag pipe.

## Test plan
- Single read: `req2`=1, `addr2`=5, RAM[5]=0x12345678 at T0 → `gnt2` at T1, `ram_addr`=5, `ram_wren`=0; `rvalid2`=1 with `rdata`=0x12345678 at T2; no other `rvalid`.
- Contention: `req1` and `req2` held high for 6 cycles, loader idle → grants alternate 1,2,1,2,1,2 starting with 1 after reset; adding `req0` mid-stream → 0 wins the next cycle.
- Locked read-modify-write: rope reads addr 3 with `lock2`=1 while draw requests continuously → draw gets no grant until rope writes addr 3 with `lock2`=0. Draw's next read of addr 3 returns the written value.
- Lock timeout: LOCK_MAX=4, rope locks then drops `req2` while holding `lock2` → FREE after 4 idle cycles, `lock_err`=1, pending `req1` granted the cycle after release.
- Enable/reset: `enable`=0 with all requests high → no `gnt` for 10 cycles, then resumes. Assert `resetn`=0 one cycle after a read grant → no `rvalid` for that read; all outputs 0 the cycle after reset.
- RD_LAT=2 build: back-to-back reads by 1 then 2 → `rvalid1` at T+3, `rvalid2` at T+4, correct data for each.
